// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide unit: controller function codes and FSM states.
package muldiv_pkg;

  localparam logic [3:0] mulDisable = 4'd0;
  localparam logic [3:0] mulMULT    = 4'd1;
  localparam logic [3:0] mulMULTU   = 4'd2;
  localparam logic [3:0] mulDIV     = 4'd3;
  localparam logic [3:0] mulDIVU    = 4'd4;
  localparam logic [3:0] mulSetHI   = 4'd5;
  localparam logic [3:0] mulSetLO   = 4'd6;
  localparam logic [3:0] mulMADD    = 4'd7;
  localparam logic [3:0] mulMADDU   = 4'd8;
  localparam logic [3:0] mulMSUB    = 4'd9;
  localparam logic [3:0] mulMSUBU   = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // Signed variants sign-extend operands; the rest treat them as unsigned.
  function automatic logic is_signed_op(input logic [3:0] func);
    return (func == mulMULT) || (func == mulDIV) || (func == mulMADD) || (func == mulMSUB);
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle after a start pulse.
module muldiv_divider #(
  parameter int STEPS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  localparam int STEP_W = $clog2(STEPS + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  logic [31:0]       rem_q, rem_d;
  logic [31:0]       quo_q, quo_d;
  logic [31:0]       dvs_q, dvs_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              run_q, run_d;
  logic [32:0]       shifted;
  logic [32:0]       trial;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    step_d  = step_q;
    run_d   = run_q;
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dvs_q};
    if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      step_d = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      // Partial remainder stays below the divisor, so 33 bits never overflow.
      rem_d  = trial[32] ? shifted[31:0] : trial[31:0];
      quo_d  = {quo_q[30:0], ~trial[32]};
      step_d = step_q + STEP_W'(1);
      if (step_q == LAST_STEP) run_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      step_q <= step_d;
      run_q  <= run_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = run_q && (step_q == LAST_STEP);

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO owner for multiply/divide/accumulate; busy while an operation is in flight.
// Optional MULDIV_FLUSH_EN adds a flush input that aborts the in-flight operation.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_BITS   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef MULDIV_FLUSH_EN
  input  logic        flush,
`endif
  input  logic [3:0]  mul_func,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_BITS) ? MUL_CYCLES : DIV_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_BITS - 1);

  logic flush_w;
`ifdef MULDIV_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [63:0]      prod_q, prod_d;
  logic [31:0]      a_q, a_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        sgn;
  logic [63:0] ext_a, ext_b, acc;
  logic        div_start, div_done;
  logic [31:0] div_dividend, div_divisor, div_quot, div_rem;

  muldiv_divider #(.STEPS(DIV_BITS)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quot),
    .remainder (div_rem),
    .done      (div_done)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    prod_d       = prod_q;
    a_d          = a_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    dz_d         = dz_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    div_start    = 1'b0;
    sgn          = is_signed_op(mul_func);
    ext_a        = {{32{sgn & in_a[31]}}, in_a};
    ext_b        = {{32{sgn & in_b[31]}}, in_b};
    acc          = {hi_q, lo_q};
    div_dividend = (sgn && in_a[31]) ? -in_a : in_a;
    div_divisor  = (sgn && in_b[31]) ? -in_b : in_b;

    unique case (state_q)
      ST_IDLE: begin
        case (mul_func)
          mulSetHI: hi_d = in_a;
          mulSetLO: lo_d = in_a;
          mulMULT, mulMULTU, mulMADD, mulMADDU, mulMSUB, mulMSUBU: begin
            op_d    = mul_func;
            prod_d  = ext_a * ext_b;
            cnt_d   = MUL_LOAD;
            state_d = ST_MUL;
          end
          mulDIV, mulDIVU: begin
            op_d      = mul_func;
            a_d       = in_a;
            q_neg_d   = sgn & (in_a[31] ^ in_b[31]);
            r_neg_d   = sgn & in_a[31];
            dz_d      = (in_b == '0);
            cnt_d     = DIV_LOAD;
            div_start = 1'b1;
            state_d   = ST_DIV;
          end
          default: ;
        endcase
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          case (op_q)
            mulMADD, mulMADDU: {hi_d, lo_d} = acc + prod_q;
            mulMSUB, mulMSUBU: {hi_d, lo_d} = acc - prod_q;
            default:           {hi_d, lo_d} = prod_q;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (div_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (dz_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = a_q;
        end else begin
          lo_d = q_neg_q ? -div_quot : div_quot;
          hi_d = r_neg_q ? -div_rem : div_rem;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides everything: no issue, no commit, back to idle.
    if (flush_w) begin
      state_d   = ST_IDLE;
      hi_d      = hi_q;
      lo_d      = lo_q;
      div_start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= mulDisable;
      prod_q  <= '0;
      a_q     <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      prod_q  <= prod_d;
      a_q     <= a_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Execute-stage responder for the decoder's multiply/divide function code.
- Performs MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU and the MTHI/MTLO writes.
- Owns the architectural HI/LO registers; MFHI/MFLO read them through the ALU output mux.
- Multi-cycle: raises busy so the hazard logic stalls any later mul-class instruction or HI/LO read.

Parameters:
MUL_CYCLES, 5, cycles from issue until a multiply-class result commits to HI/LO (minimum 1)
DIV_BITS, 32, number of iterative divide steps (one quotient bit per cycle)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
mul_func  input  4  function code from controller (shared constants); mulDisable = no-op
in_a  input  32  rs operand
in_b  input  32  rt operand
busy  output  1  operation in progress; HI/LO not yet valid
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, rst_n low): hi=0, lo=0, busy=0, state=IDLE, all counters and internal state 0. Reset during an operation aborts it; no partial HI/LO write.
- Issue: mul_func != mulDisable is sampled at a rising edge only while state=IDLE. Codes arriving while busy=1 are ignored (hazard unit guarantees a stall). Undefined codes are treated as mulDisable.
- busy = (state != IDLE), decoded directly from the state register.
- States:
  - IDLE
  - MUL: counter loaded with MUL_CYCLES-1.
  - DIV: counter loaded with DIV_BITS-1.
  - FIX: 1 cycle, applies the sign correction.
- MTHI / MTLO:
  - No state change; hi (or lo) = in_a at the issue edge.
  - busy stays 0.
  - Back-to-back issue allowed.
- MULT / MULTU:
  - Operands signed or unsigned; 64-bit product registered at the issue edge.
  - {hi,lo}=product at edge N+MUL_CYCLES; busy high for MUL_CYCLES cycles.
- MADD / MADDU / MSUB / MSUBU:
  - Same timing as MULT.
  - {hi,lo} = {hi,lo} ± product, modulo 2^64.
  - Uses the HI/LO values current at commit time, which equal the issue-time values because no write can intervene.
- DIV / DIVU:
  - Restoring divide on operand magnitudes (unsigned operands for DIVU), one quotient bit per DIV state cycle.
  - FIX: quotient negated if the operand signs differ (DIV only); remainder takes the sign of the dividend.
  - lo=quotient, hi=remainder written at edge N+DIV_BITS+1; busy high for DIV_BITS+1 cycles.
- Divide boundaries (deterministic; architecturally unpredictable cases pinned down):
  - Divisor 0: lo=32'hFFFF_FFFF, hi=in_a.
  - DIV with 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
  - Latency is unchanged in both boundary cases.
- hi/lo outputs change only on commit edges, MTHI/MTLO edges, or reset; between those edges they hold.
- Same-edge events: the commit edge returns state to IDLE, so a new issue is accepted on the following edge, never the commit edge itself.

Optional Feature:
- Macro MULDIV_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit), for the exception/eret path.
  - flush=1 at an edge forces state=IDLE and discards the in-flight operation; hi/lo keep their pre-issue values.
  - If flush coincides with a commit edge, flush wins and there is no write.
  - flush during IDLE also suppresses a same-edge issue, including MTHI/MTLO.
- Undefined: port absent; every issued operation runs to completion.

Decomposition:
- Shared constants file gets the mul function codes:
  - mulDisable=0, mulMULT=1, mulMULTU=2, mulDIV=3, mulDIVU=4
  - mulSetHI=5, mulSetLO=6
  - mulMADD=7, mulMADDU=8, mulMSUB=9, mulMSUBU=10
  - State encodings IDLE/MUL/DIV/FIX.
- One sub-module: muldiv_divider, the iterative unsigned restoring core.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, done.
  - Sign pre/post-processing stays in muldiv_unit.

Test Plan:
- MULT in_a=32'hFFFF_FFFE (-2), in_b=3 -> busy 5 cycles; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA. MULTU with the same operands -> hi=2, lo=32'hFFFF_FFFA.
- DIV in_a=-7, in_b=2 -> busy 33 cycles; lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- Divide boundaries: DIVU 5/0 -> lo=32'hFFFF_FFFF, hi=5. DIV 32'h8000_0000/32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.
- MTHI 1; MTLO 32'hFFFF_FFFF; then MADDU 1*1 -> hi=2, lo=0. MSUB 1*1 from {0,0} -> hi=lo=32'hFFFF_FFFF.
- Issue DIV, then present MULT while busy=1 -> MULT ignored; only the DIV result commits. Deassert rst_n mid-DIV -> busy=0, hi=lo=0 immediately.
- (MULDIV_FLUSH_EN) MTLO 9; then MULT 3*4; flush at cycle 2 -> busy drops next edge; lo stays 9. Flush on the commit edge -> lo stays 9.
